// File: rtl/graph_window_stats.sv
// Windowed graph statistics: node CAM plus adjacency bit-matrix,
// reporting unique nodes, unique edges and message count per window.
module graph_window_stats #(
  parameter int ID_WIDTH   = 11,
  parameter int MAX_NODES  = 32,
  parameter int WINSIZE    = 200,
  parameter int EDGE_WIDTH = 16,
  parameter int UNDIRECTED = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ID_WIDTH-1:0]            in_id,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(MAX_NODES+1)-1:0] out_nodes,
  output logic [EDGE_WIDTH-1:0]          out_edges,
  output logic [$clog2(WINSIZE+1)-1:0]   out_msgs,
  output logic                           out_overflow
);

  localparam int NW = $clog2(MAX_NODES+1);
  localparam int IW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int MW = $clog2(WINSIZE+1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] UPDATE = 3'd2;
  localparam logic [2:0] REPORT = 3'd3;
  localparam logic [2:0] CLEAR  = 3'd4;

  logic [2:0]            state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ID_WIDTH-1:0]   node_id [MAX_NODES];
  logic [MAX_NODES-1:0]  node_vld;
  logic [MAX_NODES-1:0]  adj [MAX_NODES];
  logic [NW-1:0]         node_count;
  logic [EDGE_WIDTH-1:0] edge_count;
  logic [MW-1:0]         msg_count;
  logic [IW-1:0]         pred;
  logic                  pred_valid;
  logic                  overflow;
  logic                  match_q;
  logic [IW-1:0]         idx_q;

  logic                  accept;
  logic                  hit;
  logic [IW-1:0]         hit_idx;
  logic                  full;
  logic                  add_ok;
  logic [IW-1:0]         cur;
  logic                  known;
  logic                  new_edge;
  logic [MW-1:0]         msg_next;

  assign in_ready     = (state == IDLE) && !flush;
  assign accept       = in_valid && in_ready;
  assign out_valid    = (state == REPORT);
  assign out_nodes    = node_count;
  assign out_edges    = edge_count;
  assign out_msgs     = msg_count;
  assign out_overflow = overflow;

  // Lowest matching entry wins; entries are unique so at most one hits.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = MAX_NODES - 1; i >= 0; i--) begin
      if (node_vld[i] && node_id[i] == id_q) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    full     = (node_count == NW'(MAX_NODES));
    add_ok   = match_q || !full;
    cur      = match_q ? idx_q : node_count[IW-1:0];
    known    = (UNDIRECTED != 0) ? (adj[pred][cur] && adj[cur][pred])
                                 : adj[pred][cur];
    new_edge = pred_valid && (pred != cur) && !known;
    msg_next = msg_count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      id_q       <= '0;
      node_vld   <= '0;
      node_count <= '0;
      edge_count <= '0;
      msg_count  <= '0;
      pred       <= '0;
      pred_valid <= 1'b0;
      overflow   <= 1'b0;
      match_q    <= 1'b0;
      idx_q      <= '0;
      for (int i = 0; i < MAX_NODES; i++) begin
        node_id[i] <= '0;
        adj[i]     <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id_q  <= in_id;
            state <= LOOKUP;
          end else if (flush && msg_count != '0) begin
            state <= REPORT;
          end
        end
        LOOKUP: begin
          match_q <= hit;
          idx_q   <= hit_idx;
          state   <= UPDATE;
        end
        UPDATE: begin
          msg_count <= msg_next;
          if (!add_ok) begin
            // Untracked node breaks the chain: no edge into or out of it.
            overflow   <= 1'b1;
            pred_valid <= 1'b0;
          end else begin
            if (!match_q) begin
              node_id[cur]  <= id_q;
              node_vld[cur] <= 1'b1;
              node_count    <= node_count + 1'b1;
            end
            if (new_edge) begin
              adj[pred][cur] <= 1'b1;
              if (UNDIRECTED != 0) adj[cur][pred] <= 1'b1;
              if (edge_count != '1) edge_count <= edge_count + 1'b1;
            end
            pred       <= cur;
            pred_valid <= 1'b1;
          end
          state <= (msg_next == MW'(WINSIZE)) ? REPORT : IDLE;
        end
        REPORT: begin
          if (out_ready) state <= CLEAR;
        end
        CLEAR: begin
          node_vld   <= '0;
          node_count <= '0;
          edge_count <= '0;
          msg_count  <= '0;
          pred_valid <= 1'b0;
          overflow   <= 1'b0;
          for (int i = 0; i < MAX_NODES; i++) adj[i] <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_graph_window_stats.sv
// Directed bench for graph_window_stats across four parameter sets.
module tb_graph_window_stats;

  localparam int N0 = $clog2(33);
  localparam int N2 = $clog2(3);
  localparam int M4 = $clog2(5);
  localparam int M8 = $clog2(9);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vld  [4];
  logic        rdy  [4];
  logic [10:0] id   [4];
  logic        fl   [4];
  logic        ovld [4];
  logic        ordy [4];
  logic        oovf [4];
  int          onod [4];
  int          oedg [4];
  int          omsg [4];

  logic [N0-1:0] n0, n1, n3;
  logic [N2-1:0] n2;
  logic [15:0]   e0, e1, e2, e3;
  logic [M4-1:0] m0, m1, m2;
  logic [M8-1:0] m3;

  graph_window_stats #(.WINSIZE(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_id(id[0]), .flush(fl[0]), .out_valid(ovld[0]),
    .out_ready(ordy[0]), .out_nodes(n0), .out_edges(e0),
    .out_msgs(m0), .out_overflow(oovf[0]));

  graph_window_stats #(.WINSIZE(4), .UNDIRECTED(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_id(id[1]), .flush(fl[1]), .out_valid(ovld[1]),
    .out_ready(ordy[1]), .out_nodes(n1), .out_edges(e1),
    .out_msgs(m1), .out_overflow(oovf[1]));

  graph_window_stats #(.WINSIZE(4), .MAX_NODES(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_id(id[2]), .flush(fl[2]), .out_valid(ovld[2]),
    .out_ready(ordy[2]), .out_nodes(n2), .out_edges(e2),
    .out_msgs(m2), .out_overflow(oovf[2]));

  graph_window_stats #(.WINSIZE(8)) u3 (
    .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(rdy[3]),
    .in_id(id[3]), .flush(fl[3]), .out_valid(ovld[3]),
    .out_ready(ordy[3]), .out_nodes(n3), .out_edges(e3),
    .out_msgs(m3), .out_overflow(oovf[3]));

  assign onod[0] = int'(n0);
  assign onod[1] = int'(n1);
  assign onod[2] = int'(n2);
  assign onod[3] = int'(n3);
  assign oedg[0] = int'(e0);
  assign oedg[1] = int'(e1);
  assign oedg[2] = int'(e2);
  assign oedg[3] = int'(e3);
  assign omsg[0] = int'(m0);
  assign omsg[1] = int'(m1);
  assign omsg[2] = int'(m2);
  assign omsg[3] = int'(m3);

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic send(input int k, input int v);
    bit done = 0;
    @(negedge clk);
    vld[k] = 1'b1;
    id[k]  = 11'(v);
    for (int t = 0; t < 50 && !done; t++) begin
      if (rdy[k]) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1 vld[k] = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic get_report(input int k, input int n, input int e,
                            input int m, input int o, input string tag);
    for (int t = 0; t < 50 && !ovld[k]; t++) @(negedge clk);
    chk({tag, "_valid"}, int'(ovld[k]), 1);
    chk({tag, "_nodes"}, onod[k], n);
    chk({tag, "_edges"}, oedg[k], e);
    chk({tag, "_msgs"},  omsg[k], m);
    chk({tag, "_ovf"},   int'(oovf[k]), o);
    @(negedge clk);
    ordy[k] = 1'b1;
    @(posedge clk);
    #1 ordy[k] = 1'b0;
  endtask

  typedef struct {
    int k;
    int ids [4];
    int n, e, m, o;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int sn, se, sm;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 0; id[k] = '0; fl[k] = 0; ordy[k] = 0;
    end

    tbl[0] = '{k:1, ids:'{5, 7, 5, 7}, n:2, e:1, m:4, o:0};
    tbl[1] = '{k:1, ids:'{3, 3, 3, 3}, n:1, e:0, m:4, o:0};
    tbl[2] = '{k:2, ids:'{1, 2, 3, 1}, n:2, e:1, m:4, o:1};
    tbl[3] = '{k:2, ids:'{7, 7, 7, 8}, n:2, e:1, m:4, o:0};
    tbl[4] = '{k:1, ids:'{2, 3, 4, 2}, n:3, e:3, m:4, o:0};
    tbl[5] = '{k:0, ids:'{9, 9, 8, 9}, n:2, e:2, m:4, o:0};
    tbl[6] = '{k:0, ids:'{1, 2, 3, 4}, n:4, e:3, m:4, o:0};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(ovld[0]), 0);
    chk("rst_in_ready",  int'(rdy[0]), 1);
    chk("rst_nodes",     onod[0], 0);
    chk("rst_msgs",      omsg[0], 0);
    rst = 1'b0;

    // Directed window with report latency, then held back-pressure.
    send(0, 5); send(0, 7); send(0, 5); send(0, 7);
    @(negedge clk);
    chk("lat_lookup_valid", int'(ovld[0]), 0);
    @(negedge clk);
    chk("lat_update_valid", int'(ovld[0]), 0);
    @(negedge clk);
    chk("lat_report_valid", int'(ovld[0]), 1);
    sn = onod[0]; se = oedg[0]; sm = omsg[0];
    chk("t1_nodes", sn, 2);
    chk("t1_edges", se, 2);
    chk("t1_msgs",  sm, 4);
    chk("t1_ovf",   int'(oovf[0]), 0);
    vld[0] = 1'b1; id[0] = 11'd42;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid",    int'(ovld[0]), 1);
      chk("bp_in_ready", int'(rdy[0]), 0);
      chk("bp_nodes",    onod[0], sn);
      chk("bp_edges",    oedg[0], se);
      chk("bp_msgs",     omsg[0], sm);
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 ordy[0] = 1'b0;
    @(negedge clk);
    vld[0] = 1'b0;
    chk("clear_in_ready",  int'(rdy[0]), 0);
    chk("clear_out_valid", int'(ovld[0]), 0);
    @(negedge clk);
    chk("idle_in_ready", int'(rdy[0]), 1);
    chk("idle_msgs",     omsg[0], 0);

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 4; j++) send(tbl[i].k, tbl[i].ids[j]);
      get_report(tbl[i].k, tbl[i].n, tbl[i].e, tbl[i].m, tbl[i].o,
                 $sformatf("vec%0d", i));
    end

    // Flush racing a valid ID: flush wins, partial window reported.
    send(3, 9); send(3, 4);
    for (int t = 0; t < 20 && !rdy[3]; t++) @(negedge clk);
    fl[3] = 1'b1; vld[3] = 1'b1; id[3] = 11'd6;
    #1 chk("flush_in_ready", int'(rdy[3]), 0);
    @(posedge clk);
    #1 begin fl[3] = 1'b0; vld[3] = 1'b0; end
    @(negedge clk);
    chk("flush_report_now", int'(ovld[3]), 1);
    get_report(3, 2, 1, 2, 0, "flush");
    for (int t = 0; t < 20 && !rdy[3]; t++) @(negedge clk);
    fl[3] = 1'b1;
    repeat (2) @(negedge clk);
    fl[3] = 1'b0;
    @(negedge clk);
    chk("empty_flush_ignored", int'(ovld[3]), 0);
    send(3, 6); send(3, 6);
    for (int t = 0; t < 20 && !rdy[3]; t++) @(negedge clk);
    fl[3] = 1'b1;
    @(posedge clk);
    #1 fl[3] = 1'b0;
    get_report(3, 1, 0, 2, 0, "flush2");

    // Asynchronous reset in the middle of a window.
    send(0, 1); send(0, 2); send(0, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_msgs",     omsg[0], 0);
    chk("arst_nodes",    onod[0], 0);
    chk("arst_edges",    oedg[0], 0);
    chk("arst_valid",    int'(ovld[0]), 0);
    chk("arst_in_ready", int'(rdy[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    send(0, 1); send(0, 2); send(0, 1); send(0, 2);
    get_report(0, 2, 2, 4, 0, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/graph_window_stats.md
Name: graph_window_stats

Overview:
- Parametrised successor to the windowed edge-counting graph block.
- Ingests a stream of node IDs over a valid/ready handshake and keeps a node table (CAM) plus an adjacency bit-matrix.
- Treats each consecutive ID pair in a window as an edge. Per window it reports unique nodes, unique edges, message count and an overflow flag.
- Adds a directed/undirected mode, a flush of partial windows, output back-pressure and node-table overflow handling.

Parameters:
- ID_WIDTH, 11, width of incoming node ID.
- MAX_NODES, 32, node table depth (CAM entries); adjacency matrix is MAX_NODES x MAX_NODES bits.
- WINSIZE, 200, messages per window.
- EDGE_WIDTH, 16, width of edge counter; saturates at 2^EDGE_WIDTH-1.
- UNDIRECTED, 0, 1 = (a,b) and (b,a) are the same edge.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  ID present.
- in_ready  out  1  block accepts ID this cycle.
- in_id  in  ID_WIDTH  node ID.
- flush  in  1  close current partial window.
- out_valid  out  1  window statistics valid.
- out_ready  in  1  consumer accepts statistics.
- out_nodes  out  $clog2(MAX_NODES+1)  unique nodes in window.
- out_edges  out  EDGE_WIDTH  unique edges in window.
- out_msgs  out  $clog2(WINSIZE+1)  messages in window.
- out_overflow  out  1  node table overflowed during window.

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready, which follows IDLE; node table, adjacency matrix, counters, predecessor-valid and overflow cleared. Reset mid-window discards the window; no report.
- in_ready = (state==IDLE) && !flush. Accept = in_valid && in_ready.
- States:
  - IDLE: on accept, register in_id and go to LOOKUP. Otherwise, if flush && msg_count>0, go to REPORT. Flush with msg_count==0 is ignored.
  - LOOKUP (1 cycle): compare the registered ID against all valid CAM entries and register match flag and index. Next state is UPDATE.
  - UPDATE (1 cycle):
    - msg_count++.
    - On no match with table not full: write ID at entry node_count, then node_count++.
    - On no match with table full: set overflow (sticky for the window), clear pred_valid, add no node or edge.
    - Otherwise, with cur = matched/new index: if pred_valid && pred != cur and bit[pred][cur] is clear (UNDIRECTED: bit[pred][cur] or bit[cur][pred] clear), set the bit (UNDIRECTED: both bits) and edge_count++ (saturating). Then pred = cur, pred_valid = 1.
    - Next state is REPORT if msg_count (after increment) == WINSIZE, else IDLE.
  - REPORT: out_valid=1. out_* hold registered counts and stay stable until out_ready; on out_valid && out_ready, go to CLEAR.
  - CLEAR (1 cycle): clear node-valid bits, adjacency matrix, counters, pred_valid and overflow. Next state is IDLE.
- Latency and throughput: ID accepted at cycle t; in_ready is high again at t+3, so max throughput is 1 ID per 3 cycles. For the last ID of a window, out_valid rises at t+3. After the report handshake, one CLEAR cycle follows, then IDLE.
- Edge rules:
  - Self-loops (same ID consecutively) are never counted.
  - The first message of a window has no predecessor.
  - Edges never span windows.
- Simultaneous flush and in_valid in IDLE: flush wins, ID is not accepted (in_ready=0), and the window is reported if non-empty.
- flush outside IDLE is ignored.
- Counts are unsigned. out_edges saturates; the other counters cannot overflow by construction.

Test Plan:
1. WINSIZE=4, UNDIRECTED=0, IDs 5,7,5,7 -> out_nodes=2, out_edges=2, out_msgs=4, out_overflow=0; out_valid at 3 cycles after the 4th accept.
2. Same stream with UNDIRECTED=1 -> out_edges=1, out_nodes=2. Then IDs 3,3,3,3 -> out_nodes=1, out_edges=0, and the second window shows no residue from the first.
3. MAX_NODES=2, WINSIZE=4, IDs 1,2,3,1 -> out_nodes=2, out_edges=1 (edge 1->2 only; 2->3 and 3->1 suppressed), out_overflow=1.
4. WINSIZE=8, IDs 9,4, then flush asserted together with in_valid (ID 6) -> ID 6 not accepted; report out_msgs=2, out_nodes=2, out_edges=1.
5. Hold out_ready=0 for 5 cycles during REPORT with in_valid=1 -> out_* stable, in_ready=0 throughout; after the handshake, one CLEAR cycle, then in_ready=1.
6. Assert rst asynchronously after 3 of 4 IDs -> outputs 0 immediately. Then IDs 1,2,1,2 -> out_nodes=2, out_edges=2, out_msgs=4.
